// File: rtl/alu_disp_pkg.sv
// Purpose: shared types and constants for the ALU result display (FSM states, glyphs, step count).
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_disp_pkg;

    // Capture/commit FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One shift-add-3 iteration per bit of the 9-bit captured value.
    localparam int CONV_STEPS = 9;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;

    // BCD digit to segment pattern; non-decimal codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = GLYPH_0;
            4'd1:    pat = GLYPH_1;
            4'd2:    pat = GLYPH_2;
            4'd3:    pat = GLYPH_3;
            4'd4:    pat = GLYPH_4;
            4'd5:    pat = GLYPH_5;
            4'd6:    pat = GLYPH_6;
            4'd7:    pat = GLYPH_7;
            4'd8:    pat = GLYPH_8;
            4'd9:    pat = GLYPH_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/alu_result_display_bin9_to_bcd.sv
// Purpose: sequential double-dabble converter, 9-bit binary to three BCD digits.
// Latency: start edge loads the operand, then CONV_STEPS edges of shift-add-3; digits valid after the last.
// Backpressure: none; a start while running restarts the conversion (the caller only starts when idle).
//
// Ports: clk, rst (sync, active-high), start (load bin and begin), bin[8:0],
//        done (high in the cycle whose closing edge performs the final shift),
//        hundreds/tens/ones [3:0] (scratch digits; final once the last shift has happened).
module bin9_to_bcd
    import alu_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [3:0] LAST_STEP = 4'(CONV_STEPS - 1);

    // The binary shift register doubles as the capture register for the value.
    logic [8:0]  bin_sh;
    logic [11:0] bcd;
    logic [3:0]  step;
    logic        running;

    logic [11:0] bcd_adj;
    logic [20:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        shifted = {bcd_adj, bin_sh} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sh  <= '0;
            bcd     <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (start) begin
            bin_sh  <= bin;
            bcd     <= '0;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            bcd     <= shifted[20:9];
            bin_sh  <= shifted[8:0];
            step    <= step + 4'd1;
            if (step == LAST_STEP) begin
                running <= 1'b0;
            end
        end
    end

    assign done     = running && (step == LAST_STEP);
    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/alu_result_display.sv
// Purpose: capture adder result {cout,sum}, convert to BCD, drive a 4-digit muxed common-anode display.
// Latency: load at edge k -> new digits committed at edge k+10, visible on seg from edge k+11.
// Backpressure: busy high for 10 cycles; loads seen while busy are dropped, not queued.
//
// Ports: clk, rst (sync, active-high), load, sum[7:0], cout -> busy, an[3:0] (active-low,
//        one-hot, an[0] = ones), seg[6:0] {g,f,e,d,c,b,a} active-low, dp (always off).
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int DIGIT_PERIOD  = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] sum,
    input  logic       cout,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(DIGIT_PERIOD - 1);

    state_t state, state_nxt;

    logic       conv_start;
    logic       conv_done;
    logic [3:0] scr_h, scr_t, scr_o;

    // Committed digits: the only digits the mux ever sees.
    logic [3:0] dig_h, dig_t, dig_o;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;

    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;

    // ---------------- capture / commit FSM ----------------
    assign conv_start = (state == ST_IDLE) && load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load)      state_nxt = ST_SHIFT;
            ST_SHIFT:  if (conv_done) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // state is a register, so busy is registered too.
    assign busy = (state != ST_IDLE);

    bin9_to_bcd u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .bin      ({cout, sum}),
        .done     (conv_done),
        .hundreds (scr_h),
        .tens     (scr_t),
        .ones     (scr_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_h <= '0;
            dig_t <= '0;
            dig_o <= '0;
        end else if (state == ST_COMMIT) begin
            dig_h <= scr_h;
            dig_t <= scr_t;
            dig_o <= scr_o;
        end
    end

    // ---------------- refresh timing ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // ---------------- digit mux and glyph lookup ----------------
    always_comb begin
        an_nxt  = ~(4'b0001 << digit_idx);
        seg_nxt = SEG_BLANK;
        case (digit_idx)
            2'd0: seg_nxt = bcd_to_seg(dig_o);
            2'd1: seg_nxt = (BLANK_LEADING && dig_h == 4'd0 && dig_t == 4'd0)
                            ? SEG_BLANK : bcd_to_seg(dig_t);
            2'd2: seg_nxt = (BLANK_LEADING && dig_h == 4'd0)
                            ? SEG_BLANK : bcd_to_seg(dig_h);
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // Anode and pattern share one register stage so they always switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= GLYPH_0;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] sum;
    logic       cout;

    logic       busy1, dp1, busy0, dp0;
    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph_tab [10];

    always #5 clk = ~clk;

    alu_result_display #(.DIGIT_PERIOD(DP), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .sum(sum), .cout(cout),
        .busy(busy1), .an(an1), .seg(seg1), .dp(dp1)
    );

    alu_result_display #(.DIGIT_PERIOD(DP), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .sum(sum), .cout(cout),
        .busy(busy0), .an(an0), .seg(seg0), .dp(dp0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected pattern for one digit position, straight from decimal arithmetic.
    function automatic logic [6:0] exp_seg(input int value, input int pos, input bit blank);
        int h, t, o;
        h = value / 100;
        t = (value / 10) % 10;
        o = value % 10;
        case (pos)
            0:       return glyph_tab[o];
            1:       return (blank && h == 0 && t == 0) ? 7'h7F : glyph_tab[t];
            2:       return (blank && h == 0) ? 7'h7F : glyph_tab[h];
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int an_to_pos(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Watch one full refresh round (plus margin) and check every lit digit.
    task automatic scan_display(input int value, input string tag);
        int p1, p0;
        tick();
        for (int n = 0; n < 4 * DP + 4; n++) begin
            p1 = an_to_pos(an1);
            p0 = an_to_pos(an0);
            check_eq({tag, " an_onehot"}, 32'(p1 >= 0 && p0 >= 0), 32'd1);
            if (p1 >= 0) check_eq($sformatf("%s seg pos%0d", tag, p1), 32'(seg1), 32'(exp_seg(value, p1, 1'b1)));
            if (p0 >= 0) check_eq($sformatf("%s seg_nb pos%0d", tag, p0), 32'(seg0), 32'(exp_seg(value, p0, 1'b0)));
            check_eq({tag, " dp"}, 32'({dp1, dp0}), 32'd3);
            tick();
        end
    endtask

    // Issue a one-cycle load and count busy samples (bounded).
    task automatic do_load(input int value, output int busy_cycles);
        logic [8:0] v;
        v    = 9'(value);
        sum  = v[7:0];
        cout = v[8];
        load = 1'b1;
        tick();
        load = 1'b0;
        busy_cycles = 0;
        while (busy1 && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
    endtask

    task automatic convert_and_check(input int value);
        int bc;
        do_load(value, bc);
        check_eq($sformatf("busy_len %0d", value), 32'(bc), 32'd10);
        scan_display(value, $sformatf("val%0d", value));
    endtask

    initial begin
        int prev_an, run, changes, bc, stray;
        int directed [8] = '{255, 511, 7, 0, 10, 99, 100, 109};

        glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001;
        glyph_tab[2] = 7'b0100100; glyph_tab[3] = 7'b0110000;
        glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
        glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000;
        glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0010000;

        rst = 1'b1; load = 1'b1; sum = 8'hAA; cout = 1'b1;
        tick();
        tick();
        check_eq("rst busy", 32'(busy1), 32'd0);
        check_eq("rst an", 32'(an1), 32'b1110);
        check_eq("rst seg", 32'(seg1), 32'b1000000);
        check_eq("rst dp", 32'(dp1), 32'd1);
        rst = 1'b0; load = 1'b0;

        // Refresh rotation while idle: each anode lit DP cycles, order 0,1,2,3.
        prev_an = int'(an1); run = 0; changes = 0;
        for (int n = 0; n < 8 * DP; n++) begin
            run++;
            tick();
            check_eq("idle busy", 32'(busy1), 32'd0);
            check_eq("idle an_onehot", 32'(an_to_pos(an1) >= 0), 32'd1);
            if (int'(an1) != prev_an) begin
                check_eq("an_rotate", 32'(an1), 32'({prev_an[2:0], prev_an[3]}));
                if (changes > 0) check_eq("an_dwell", 32'(run), 32'(DP));
                changes++;
                run = 0;
                prev_an = int'(an1);
            end
            if (an_to_pos(an1) == 0) check_eq("idle seg ones", 32'(seg1), 32'b1000000);
            else                     check_eq("idle seg blank", 32'(seg1), 32'b1111111);
        end
        check_eq("an_changes", 32'(changes >= 6), 32'd1);

        foreach (directed[i]) convert_and_check(directed[i]);
        for (int i = 0; i < 16; i++) convert_and_check(int'($urandom_range(0, 511)));

        // Load while busy is dropped.
        sum = 8'd100; cout = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        bc = 1;
        tick(); bc += int'(busy1);
        tick(); bc += int'(busy1);
        sum = 8'd42; load = 1'b1;
        tick();
        load = 1'b0;
        while (busy1 && bc < 40) begin
            bc++;
            tick();
        end
        check_eq("ignored busy_len", 32'(bc), 32'd10);
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            stray += int'(busy1);
            tick();
        end
        check_eq("ignored no requeue", 32'(stray), 32'd0);
        scan_display(100, "ignored");

        // Reset during SHIFT together with load aborts; display goes to 0.
        sum = 8'd200; cout = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        check_eq("pre-abort busy", 32'(busy1), 32'd1);
        rst = 1'b1; load = 1'b1;
        tick();
        check_eq("abort busy", 32'(busy1), 32'd0);
        check_eq("abort an", 32'(an1), 32'b1110);
        check_eq("abort seg", 32'(seg1), 32'b1000000);
        rst = 1'b0; load = 1'b0;
        stray = 0;
        for (int n = 0; n < 15; n++) begin
            stray += int'(busy1);
            tick();
        end
        check_eq("abort no busy", 32'(stray), 32'd0);
        scan_display(0, "abort");

        // A fresh conversion still works after the abort.
        convert_and_check(255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
